// File: rtl/zpu_sd_bridge.sv
`timescale 1ns / 1ps
// zpu_sd_bridge
// Bridges ZPU command strobes to the hps_io SD block-device interface.
// A shared 2^BUF_AW x 8 sector buffer is seen by hps_io on port A and by
// the ZPU through an auto-incrementing pointer on port B.
//
// Ports
//   clk_sys, areset           : clock and synchronous active-high reset
//   cmd_*                     : single-cycle ZPU command strobes + data/drive
//   buf_wr/buf_rd/buf_rst     : ZPU buffer pointer controls; buf_q/buf_ptr out
//   io_done, io_err           : transfer status
//   sd_lba, sd_rd, sd_wr      : request to hps_io (sd_rd/sd_wr one-hot per drive)
//   sd_ack, sd_buff_*         : hps_io handshake and buffer port A
//   img_*                     : hps_io mount notification
//   mnt_*                     : last-mount report (mnt_toggle flips per mount)
//
// Build option: define SD_BRIDGE_TIMEOUT_EN to add a transfer watchdog that
// aborts REQ/XFER after TIMEOUT_CYC cycles. Without it TIMEOUT_CYC is unused.
module zpu_sd_bridge #(
  parameter int                 NUM_DRV     = 4,
  parameter int                 BUF_AW      = 9,
  parameter logic [NUM_DRV-1:0] RO_MASK     = '0,
  parameter int                 TIMEOUT_CYC = 50000000,
  localparam int                DW          = $clog2(NUM_DRV)
) (
  input  logic               clk_sys,
  input  logic               areset,
  input  logic [31:0]        cmd_data,
  input  logic [DW-1:0]      cmd_drv,
  input  logic               cmd_lba_wr,
  input  logic               cmd_rd,
  input  logic               cmd_wr,
  input  logic               buf_wr,
  input  logic               buf_rd,
  input  logic               buf_rst,
  output logic [7:0]         buf_q,
  output logic [BUF_AW-1:0]  buf_ptr,
  output logic               io_done,
  output logic               io_err,
  output logic [31:0]        sd_lba,
  output logic [NUM_DRV-1:0] sd_rd,
  output logic [NUM_DRV-1:0] sd_wr,
  input  logic               sd_ack,
  input  logic [BUF_AW-1:0]  sd_buff_addr,
  input  logic [7:0]         sd_buff_dout,
  input  logic               sd_buff_wr,
  output logic [7:0]         sd_buff_din,
  input  logic [NUM_DRV-1:0] img_mounted,
  input  logic               img_readonly,
  input  logic [63:0]        img_size,
  output logic               mnt_toggle,
  output logic [DW-1:0]      mnt_drv,
  output logic               mnt_ro,
  output logic [31:0]        mnt_size
);

  // Drive indices span 2^DW codes; codes >= NUM_DRV are invalid.
  localparam int                BUF_SZ      = 1 << BUF_AW;
  localparam int                SLOTS       = 1 << DW;
  localparam logic [SLOTS-1:0]  DRV_OK      = SLOTS'((64'd1 << NUM_DRV) - 64'd1);
  localparam logic [SLOTS-1:0]  RO_MASK_EXT = SLOTS'(RO_MASK);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t           state_q, state_d;
  logic             start_ok, start_rej, xfer_end, tmo_hit;
  logic             is_wr, cmd_ok;
  logic [SLOTS-1:0] cmd_sel;
  logic [SLOTS-1:0] ro_flag;

  // ---------------------------------------------------------------- buffer
  logic [7:0] mem [BUF_SZ];

  // NOTE: the buffer array has no reset so it maps onto block RAM and keeps
  // its sector data across areset.
  always_ff @(posedge clk_sys) begin
    if (sd_buff_wr) mem[sd_buff_addr] <= sd_buff_dout;
    if (buf_wr)     mem[buf_ptr]      <= cmd_data[7:0];
    sd_buff_din <= mem[sd_buff_addr];
    buf_q       <= mem[buf_ptr];
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (areset || buf_rst)    buf_ptr <= '0;
    else if (buf_wr || buf_rd) buf_ptr <= buf_ptr + 1'b1;
  end

  // ------------------------------------------------------------ command fsm
  assign is_wr   = cmd_wr && !cmd_rd;
  assign cmd_sel = SLOTS'(1) << cmd_drv;
  assign cmd_ok  = DRV_OK[cmd_drv] && !(is_wr && ro_flag[cmd_drv]);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a value held, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_rej = 1'b0;
    xfer_end  = 1'b0;
    case (state_q)
      IDLE: if (cmd_rd || cmd_wr) begin
        if (cmd_ok) begin
          state_d  = REQ;
          start_ok = 1'b1;
        end else begin
          start_rej = 1'b1;
        end
      end
      REQ:  if (sd_ack) state_d = XFER;
      XFER: if (!sd_ack) begin
        state_d  = IDLE;
        xfer_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (tmo_hit) state_d = IDLE;
  end

  always_ff @(posedge clk_sys) begin
    if (areset) begin
      state_q <= IDLE;
      sd_rd   <= '0;
      sd_wr   <= '0;
      sd_lba  <= '0;
      io_done <= 1'b1;
      io_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_lba_wr) sd_lba <= cmd_data;
      if (start_ok) begin
        io_done <= 1'b0;
        io_err  <= 1'b0;
        if (is_wr) sd_wr <= NUM_DRV'(cmd_sel);
        else       sd_rd <= NUM_DRV'(cmd_sel);
      end
      if (start_rej) begin
        io_done <= 1'b1;
        io_err  <= 1'b1;
      end
      // Request is withdrawn as soon as hps_io acknowledges it.
      if (state_q == REQ && sd_ack) begin
        sd_rd <= '0;
        sd_wr <= '0;
      end
      if (xfer_end) io_done <= 1'b1;
      if (tmo_hit) begin
        sd_rd   <= '0;
        sd_wr   <= '0;
        io_done <= 1'b1;
        io_err  <= 1'b1;
      end
    end
  end

`ifdef SD_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // The first busy cycle counts as 0, so the abort lands after exactly
  // TIMEOUT_CYC cycles of asserted request/transfer.
  assign tmo_hit = (state_q != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_sys) begin
    if (areset || state_q == IDLE) tmo_cnt <= '0;
    else                           tmo_cnt <= tmo_cnt + 1'b1;
  end

  logic unused_ok;
  assign unused_ok = ^img_size[63:32];
`else
  assign tmo_hit = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{img_size[63:32], 32'(TIMEOUT_CYC)};
`endif

  // ------------------------------------------------------------------ mount
  logic          mnt_any, mnt_prev, mnt_rise, mnt_ro_d;
  logic [DW-1:0] mnt_idx;

  assign mnt_any  = |img_mounted;
  assign mnt_rise = mnt_any && !mnt_prev;

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    mnt_idx = '0;
    for (int i = NUM_DRV - 1; i >= 0; i--) begin
      if (img_mounted[i]) mnt_idx = DW'(i);
    end
  end

  assign mnt_ro_d = img_readonly | RO_MASK_EXT[mnt_idx];

  // Independent of the command FSM: a mount never disturbs a transfer.
  always_ff @(posedge clk_sys) begin
    // Prime the edge detector in reset so an image already mounted is not
    // reported again when reset releases.
    mnt_prev <= mnt_any;
    if (areset) begin
      mnt_toggle <= 1'b0;
      mnt_drv    <= '0;
      mnt_ro     <= 1'b0;
      mnt_size   <= '0;
      ro_flag    <= '0;
    end else if (mnt_rise) begin
      mnt_toggle       <= ~mnt_toggle;
      mnt_drv          <= mnt_idx;
      mnt_ro           <= mnt_ro_d;
      mnt_size         <= img_size[31:0];
      ro_flag[mnt_idx] <= mnt_ro_d;
    end
  end

endmodule

// File: tb/tb_zpu_sd_bridge.sv
`timescale 1ns / 1ps
// tb_zpu_sd_bridge
// Directed self-checking bench for zpu_sd_bridge (NUM_DRV=4, BUF_AW=9,
// TIMEOUT_CYC=100). Inputs change 1 ns after the rising edge and outputs are
// sampled at the same point, so each tick() shows the result of one edge.
module tb_zpu_sd_bridge;

  logic        clk_sys = 1'b0;
  logic        areset  = 1'b1;
  logic [31:0] cmd_data = '0;
  logic [1:0]  cmd_drv  = '0;
  logic        cmd_lba_wr = 1'b0, cmd_rd = 1'b0, cmd_wr = 1'b0;
  logic        buf_wr = 1'b0, buf_rd = 1'b0, buf_rst = 1'b0;
  logic [7:0]  buf_q;
  logic [8:0]  buf_ptr;
  logic        io_done, io_err;
  logic [31:0] sd_lba;
  logic [3:0]  sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = '0;
  logic [7:0]  sd_buff_dout = '0;
  logic        sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_din;
  logic [3:0]  img_mounted = '0;
  logic        img_readonly = 1'b0;
  logic [63:0] img_size = '0;
  logic        mnt_toggle;
  logic [1:0]  mnt_drv;
  logic        mnt_ro;
  logic [31:0] mnt_size;

  int   errors = 0;
  int   checks = 0;
  logic exp_tog = 1'b0;

  zpu_sd_bridge #(
    .NUM_DRV(4), .BUF_AW(9), .RO_MASK(4'b0000), .TIMEOUT_CYC(100)
  ) dut (
    .clk_sys(clk_sys), .areset(areset),
    .cmd_data(cmd_data), .cmd_drv(cmd_drv), .cmd_lba_wr(cmd_lba_wr),
    .cmd_rd(cmd_rd), .cmd_wr(cmd_wr),
    .buf_wr(buf_wr), .buf_rd(buf_rd), .buf_rst(buf_rst),
    .buf_q(buf_q), .buf_ptr(buf_ptr),
    .io_done(io_done), .io_err(io_err),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .mnt_toggle(mnt_toggle), .mnt_drv(mnt_drv), .mnt_ro(mnt_ro),
    .mnt_size(mnt_size)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Issue a one-cycle command pulse; on return we are in cycle N+1.
  task automatic pulse_cmd(input logic rd, input logic wr, input logic [1:0] drv);
    cmd_drv = drv; cmd_rd = rd; cmd_wr = wr;
    tick();
    cmd_rd = 1'b0; cmd_wr = 1'b0;
  endtask

  // Acknowledge a pending request for two cycles and let it complete.
  task automatic finish_xfer();
    sd_ack = 1'b1; tick(); tick();
    sd_ack = 1'b0; tick();
  endtask

  task automatic test_reset();
    areset = 1'b1; tick(); tick();
    checks++; if (sd_rd !== 4'b0 || sd_wr !== 4'b0) begin errors++;
      $display("FAIL reset_req: sd_rd=%b sd_wr=%b want 0000", sd_rd, sd_wr); end
    checks++; if (sd_lba !== 32'h0 || buf_ptr !== 9'd0) begin errors++;
      $display("FAIL reset_lba_ptr: lba=%h ptr=%0d want 0/0", sd_lba, buf_ptr); end
    checks++; if (io_done !== 1'b1 || io_err !== 1'b0) begin errors++;
      $display("FAIL reset_status: done=%b err=%b want 1/0", io_done, io_err); end
    checks++; if ({mnt_toggle, mnt_drv, mnt_ro} !== 4'b0 || mnt_size !== 32'h0) begin errors++;
      $display("FAIL reset_mnt: tog=%b drv=%0d ro=%b size=%0d want 0", mnt_toggle, mnt_drv, mnt_ro, mnt_size); end
    areset = 1'b0; tick();
    checks++; if (io_done !== 1'b1 || sd_rd !== 4'b0) begin errors++;
      $display("FAIL reset_release: done=%b sd_rd=%b want 1/0000", io_done, sd_rd); end
  endtask

  task automatic test_read();
    cmd_data = 32'h0000_1234; cmd_lba_wr = 1'b1; tick(); cmd_lba_wr = 1'b0;
    checks++; if (sd_lba !== 32'h0000_1234) begin errors++;
      $display("FAIL lba_load: got %h want 00001234", sd_lba); end
    pulse_cmd(1'b1, 1'b0, 2'd2);
    for (int c = 0; c < 3; c++) begin
      checks++; if (sd_rd !== 4'b0100 || sd_wr !== 4'b0 || io_done !== 1'b0) begin errors++;
        $display("FAIL read_req cycle %0d: sd_rd=%b sd_wr=%b done=%b want 0100/0000/0", c, sd_rd, sd_wr, io_done); end
      if (c < 2) tick();
    end
    sd_ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (sd_rd !== 4'b0 || io_done !== 1'b0) begin errors++;
        $display("FAIL read_ack cycle %0d: sd_rd=%b done=%b want 0000/0", c, sd_rd, io_done); end
    end
    sd_ack = 1'b0;
    checks++; if (io_done !== 1'b0) begin errors++;
      $display("FAIL read_done_early: done=%b want 0 in ack-fall cycle", io_done); end
    tick();
    checks++; if (io_done !== 1'b1 || io_err !== 1'b0) begin errors++;
      $display("FAIL read_done: done=%b err=%b want 1/0", io_done, io_err); end
    // hps_io fills the sector
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr = 9'(i); sd_buff_dout = 8'(i); sd_buff_wr = 1'b1; tick();
    end
    sd_buff_wr = 1'b0; sd_buff_addr = 9'd5; tick();
    checks++; if (sd_buff_din !== 8'h05) begin errors++;
      $display("FAIL porta_read: got %h want 05", sd_buff_din); end
    // ZPU reads it back through the pointer
    buf_rst = 1'b1; tick(); buf_rst = 1'b0; tick();
    for (int i = 0; i < 512; i++) begin
      checks++; if (buf_q !== 8'(i) || buf_ptr !== 9'(i)) begin errors++;
        $display("FAIL buf_read[%0d]: q=%h ptr=%0d want %h/%0d", i, buf_q, buf_ptr, 8'(i), i); end
      buf_rd = 1'b1; tick(); buf_rd = 1'b0; tick();
    end
    checks++; if (buf_ptr !== 9'd0) begin errors++;
      $display("FAIL buf_read_wrap: ptr=%0d want 0", buf_ptr); end
  endtask

  task automatic test_mount_ro();
    img_readonly = 1'b1; img_size = 64'd92176; img_mounted = 4'b0010; tick();
    exp_tog = ~exp_tog;
    checks++; if (mnt_toggle !== exp_tog || mnt_drv !== 2'd1) begin errors++;
      $display("FAIL mount_ro_id: tog=%b drv=%0d want %b/1", mnt_toggle, mnt_drv, exp_tog); end
    checks++; if (mnt_ro !== 1'b1 || mnt_size !== 32'd92176) begin errors++;
      $display("FAIL mount_ro_attr: ro=%b size=%0d want 1/92176", mnt_ro, mnt_size); end
    img_mounted = 4'b0000; img_readonly = 1'b0; tick();
    pulse_cmd(1'b0, 1'b1, 2'd1);
    checks++; if (io_err !== 1'b1 || io_done !== 1'b1 || sd_wr !== 4'b0) begin errors++;
      $display("FAIL ro_reject: err=%b done=%b sd_wr=%b want 1/1/0000", io_err, io_done, sd_wr); end
    tick(); tick();
    checks++; if (sd_wr !== 4'b0 || sd_rd !== 4'b0 || io_done !== 1'b1) begin errors++;
      $display("FAIL ro_reject_hold: sd_wr=%b sd_rd=%b done=%b want 0/0/1", sd_wr, sd_rd, io_done); end
  endtask

  task automatic test_rw_and_mount_in_xfer();
    img_readonly = 1'b0; img_size = 64'h1_0000_0200; img_mounted = 4'b1000; tick();
    exp_tog = ~exp_tog;
    checks++; if (mnt_toggle !== exp_tog || mnt_drv !== 2'd3 || mnt_ro !== 1'b0 || mnt_size !== 32'h200) begin errors++;
      $display("FAIL mount_rw: tog=%b drv=%0d ro=%b size=%h want %b/3/0/00000200", mnt_toggle, mnt_drv, mnt_ro, mnt_size, exp_tog); end
    img_mounted = 4'b0000; tick();
    // simultaneous rd and wr: rd wins
    pulse_cmd(1'b1, 1'b1, 2'd3);
    checks++; if (sd_rd !== 4'b1000 || sd_wr !== 4'b0 || io_err !== 1'b0) begin errors++;
      $display("FAIL rd_priority: sd_rd=%b sd_wr=%b err=%b want 1000/0000/0", sd_rd, sd_wr, io_err); end
    // mount while the request is pending
    img_readonly = 1'b1; img_size = 64'd777; img_mounted = 4'b0001; tick();
    exp_tog = ~exp_tog;
    checks++; if (mnt_toggle !== exp_tog || mnt_drv !== 2'd0 || mnt_ro !== 1'b1) begin errors++;
      $display("FAIL mount_in_xfer: tog=%b drv=%0d ro=%b want %b/0/1", mnt_toggle, mnt_drv, mnt_ro, exp_tog); end
    checks++; if (sd_rd !== 4'b1000 || io_done !== 1'b0) begin errors++;
      $display("FAIL xfer_not_aborted: sd_rd=%b done=%b want 1000/0", sd_rd, io_done); end
    img_mounted = 4'b0000; img_readonly = 1'b0;
    finish_xfer();
    checks++; if (io_done !== 1'b1 || io_err !== 1'b0) begin errors++;
      $display("FAIL xfer_complete: done=%b err=%b want 1/0", io_done, io_err); end
    pulse_cmd(1'b0, 1'b1, 2'd3);
    checks++; if (sd_wr !== 4'b1000 || sd_rd !== 4'b0 || io_done !== 1'b0) begin errors++;
      $display("FAIL wr_accept: sd_wr=%b sd_rd=%b done=%b want 1000/0000/0", sd_wr, sd_rd, io_done); end
    finish_xfer();
    pulse_cmd(1'b0, 1'b1, 2'd0);
    checks++; if (sd_wr !== 4'b0 || io_err !== 1'b1 || io_done !== 1'b1) begin errors++;
      $display("FAIL wr_reject_drv0: sd_wr=%b err=%b done=%b want 0000/1/1", sd_wr, io_err, io_done); end
  endtask

  task automatic test_multi_mount();
    img_mounted = 4'b0110; tick();
    exp_tog = ~exp_tog;
    checks++; if (mnt_drv !== 2'd1 || mnt_toggle !== exp_tog) begin errors++;
      $display("FAIL multi_mount: drv=%0d tog=%b want 1/%b", mnt_drv, mnt_toggle, exp_tog); end
    tick(); tick();
    checks++; if (mnt_toggle !== exp_tog) begin errors++;
      $display("FAIL multi_single_toggle: tog=%b want %b", mnt_toggle, exp_tog); end
  endtask

  task automatic test_ptr();
    buf_rst = 1'b1; tick(); buf_rst = 1'b0;
    buf_rd = 1'b1;
    for (int i = 0; i < 511; i++) tick();
    buf_rd = 1'b0;
    checks++; if (buf_ptr !== 9'd511) begin errors++;
      $display("FAIL ptr_511: got %0d want 511", buf_ptr); end
    cmd_data = 32'h0000_00A5; buf_wr = 1'b1; buf_rd = 1'b1; tick(); buf_wr = 1'b0; buf_rd = 1'b0;
    checks++; if (buf_ptr !== 9'd0) begin errors++;
      $display("FAIL ptr_wrap: got %0d want 0 (single increment)", buf_ptr); end
    buf_rd = 1'b1; tick();
    buf_rst = 1'b1; tick(); buf_rst = 1'b0; buf_rd = 1'b0;
    checks++; if (buf_ptr !== 9'd0) begin errors++;
      $display("FAIL ptr_rst_priority: got %0d want 0", buf_ptr); end
    sd_buff_addr = 9'd511; tick();
    checks++; if (sd_buff_din !== 8'hA5) begin errors++;
      $display("FAIL bufwr_511: got %h want a5", sd_buff_din); end
    cmd_data = 32'h0000_005A; buf_wr = 1'b1; tick(); buf_wr = 1'b0;
    checks++; if (buf_ptr !== 9'd1) begin errors++;
      $display("FAIL bufwr_inc: ptr=%0d want 1", buf_ptr); end
    buf_rst = 1'b1; tick(); buf_rst = 1'b0; tick();
    sd_buff_addr = 9'd0; tick();
    checks++; if (buf_q !== 8'h5A || sd_buff_din !== 8'h5A) begin errors++;
      $display("FAIL bufwr_data: q=%h din=%h want 5a/5a", buf_q, sd_buff_din); end
  endtask

  task automatic test_timeout();
    int hi;
    pulse_cmd(1'b1, 1'b0, 2'd0);
`ifdef SD_BRIDGE_TIMEOUT_EN
    hi = 0;
    while (sd_rd !== 4'b0 && hi < 300) begin hi++; tick(); end
    checks++; if (hi !== 100) begin errors++;
      $display("FAIL timeout_len: sd_rd high %0d cycles want 100", hi); end
    checks++; if (io_err !== 1'b1 || io_done !== 1'b1) begin errors++;
      $display("FAIL timeout_status: err=%b done=%b want 1/1", io_err, io_done); end
    pulse_cmd(1'b1, 1'b0, 2'd1);
    checks++; if (sd_rd !== 4'b0010 || io_err !== 1'b0 || io_done !== 1'b0) begin errors++;
      $display("FAIL timeout_rearm: sd_rd=%b err=%b done=%b want 0010/0/0", sd_rd, io_err, io_done); end
`else
    hi = 0;
    while (sd_rd === 4'b0001 && hi < 150) begin hi++; tick(); end
    checks++; if (hi !== 150 || io_done !== 1'b0 || io_err !== 1'b0) begin errors++;
      $display("FAIL no_timeout: held %0d cycles done=%b err=%b want 150/0/0", hi, io_done, io_err); end
`endif
    finish_xfer();
    checks++; if (io_done !== 1'b1 || io_err !== 1'b0) begin errors++;
      $display("FAIL post_timeout_xfer: done=%b err=%b want 1/0", io_done, io_err); end
  endtask

  task automatic test_reset_mid_xfer();
    cmd_data = 32'hDEAD_BEEF; cmd_lba_wr = 1'b1; tick(); cmd_lba_wr = 1'b0;
    cmd_data = 32'h0000_0011; buf_wr = 1'b1; tick(); buf_wr = 1'b0;
    pulse_cmd(1'b1, 1'b0, 2'd2);
    sd_ack = 1'b1; tick();
    checks++; if (sd_rd !== 4'b0 || io_done !== 1'b0 || sd_lba !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL pre_reset_xfer: sd_rd=%b done=%b lba=%h want 0000/0/deadbeef", sd_rd, io_done, sd_lba); end
    // img_mounted is still 0110, so the primed detector must not re-fire.
    areset = 1'b1; tick();
    exp_tog = 1'b0;
    checks++; if (sd_rd !== 4'b0 || sd_wr !== 4'b0 || sd_lba !== 32'h0 || buf_ptr !== 9'd0) begin errors++;
      $display("FAIL midreset_req: sd_rd=%b sd_wr=%b lba=%h ptr=%0d want 0", sd_rd, sd_wr, sd_lba, buf_ptr); end
    checks++; if (io_done !== 1'b1 || io_err !== 1'b0) begin errors++;
      $display("FAIL midreset_status: done=%b err=%b want 1/0", io_done, io_err); end
    checks++; if ({mnt_toggle, mnt_drv, mnt_ro} !== 4'b0 || mnt_size !== 32'h0) begin errors++;
      $display("FAIL midreset_mnt: tog=%b drv=%0d ro=%b size=%0d want 0", mnt_toggle, mnt_drv, mnt_ro, mnt_size); end
    areset = 1'b0; sd_ack = 1'b0; tick(); tick();
    checks++; if (mnt_toggle !== exp_tog || io_done !== 1'b1) begin errors++;
      $display("FAIL midreset_release: tog=%b done=%b want 0/1", mnt_toggle, io_done); end
    sd_buff_addr = 9'd7; tick();
    checks++; if (sd_buff_din !== 8'h07) begin errors++;
      $display("FAIL buffer_preserved[7]: got %h want 07", sd_buff_din); end
    sd_buff_addr = 9'd0; tick();
    checks++; if (sd_buff_din !== 8'h11) begin errors++;
      $display("FAIL buffer_preserved[0]: got %h want 11", sd_buff_din); end
    // read-only flags were cleared, so a write to drive 1 is now accepted
    pulse_cmd(1'b0, 1'b1, 2'd1);
    checks++; if (sd_wr !== 4'b0010 || io_err !== 1'b0) begin errors++;
      $display("FAIL ro_flag_cleared: sd_wr=%b err=%b want 0010/0", sd_wr, io_err); end
    finish_xfer();
  endtask

  initial begin
    test_reset();
    test_read();
    test_mount_ro();
    test_rw_and_mount_in_xfer();
    test_multi_mount();
    test_ptr();
    test_timeout();
    test_reset_mid_xfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zpu_sd_bridge.md
ZPU_SD_BRIDGE -- requirements
Module: zpu_sd_bridge

Interface
REQ-001 SHALL have parameter NUM_DRV, 4, number of drive channels (2..8); DW = clog2(NUM_DRV).
REQ-002 SHALL have parameter BUF_AW, 9, sector buffer address width (buffer = 2^BUF_AW bytes).
REQ-003 SHALL have parameter RO_MASK, NUM_DRV'b0, per-drive forced read-only bits.
REQ-004 SHALL have parameter TIMEOUT_CYC, 50000000, transfer watchdog limit in clk_sys cycles.
REQ-005 SHALL have port clk_sys in 1, system clock; all logic on its rising edge.
REQ-006 SHALL have port areset in 1, reset, synchronous, active-high.
REQ-007 SHALL have ports cmd_data in 32, cmd_drv in DW, cmd_lba_wr in 1, cmd_rd in 1 and cmd_wr in 1: ZPU command inputs, all single-cycle pulses.
REQ-008 SHALL have ports buf_wr in 1 (write cmd_data[7:0] at ptr, then increment), buf_rd in 1 (increment ptr), buf_rst in 1 (ptr to 0), buf_q out 8 and buf_ptr out BUF_AW.
REQ-009 SHALL have ports io_done out 1 and io_err out 1: status bits.
REQ-010 SHALL have ports sd_lba out 32, sd_rd out NUM_DRV, sd_wr out NUM_DRV, sd_ack in 1, sd_buff_addr in BUF_AW, sd_buff_dout in 8, sd_buff_wr in 1 and sd_buff_din out 8: hps_io side.
REQ-011 SHALL have ports img_mounted in NUM_DRV, img_readonly in 1, img_size in 64, mnt_toggle out 1, mnt_drv out DW, mnt_ro out 1 and mnt_size out 32.

Function
REQ-012 SHALL implement a true dual-port 2^BUF_AW x 8 buffer: port A is the sd_buff_* side, port B is at buf_ptr; each port has 1-cycle read latency.
REQ-013 buf_ptr SHALL wrap modulo 2^BUF_AW; buf_rst has priority over increment; buf_wr and buf_rd in the same cycle SHALL write, then increment once.
REQ-014 cmd_lba_wr SHALL load sd_lba <= cmd_data in IDLE only; it is ignored otherwise.
REQ-015 FSM states SHALL be IDLE, REQ, XFER. Commands are accepted in IDLE only; when both cmd_rd and cmd_wr pulse, cmd_rd wins.
REQ-016 Accepted cmd_rd/cmd_wr at cycle N SHALL set io_done=0, io_err=0, latch drv, assert sd_rd[drv] or sd_wr[drv] (one-hot) at N+1, and enter REQ.
REQ-017 The REQ to XFER transition SHALL occur on sd_ack=1; sd_rd and sd_wr SHALL be 0 from the next cycle onward.
REQ-018 The XFER to IDLE transition SHALL occur on the first cycle with sd_ack=0; io_done=1 on the following cycle.
REQ-019 Reject cases SHALL be cmd_drv>=NUM_DRV, or cmd_wr to a drive whose mount was read-only. A reject issues no sd_rd/sd_wr, sets io_err=1 and io_done=1 at N+1, and stays in IDLE.
REQ-020 A rising edge of |img_mounted SHALL capture the lowest set index into mnt_drv, set mnt_ro = img_readonly | RO_MASK[idx], set mnt_size = img_size[31:0], store a per-drive ro flag, and toggle mnt_toggle.
REQ-021 A mount during an active transfer SHALL update mount state only and SHALL NOT abort the transfer.

Reset
REQ-022 areset SHALL force: FSM=IDLE, sd_rd=sd_wr=0, sd_lba=0, buf_ptr=0, io_done=1, io_err=0, mnt_toggle=0, mnt_drv=0, mnt_ro=0, mnt_size=0, per-drive ro flags=0, and the edge detector primed to the current |img_mounted.
REQ-023 areset mid-transfer SHALL drop the request on the next cycle; buffer contents SHALL be preserved.

Configuration
REQ-024 With macro SD_BRIDGE_TIMEOUT_EN defined, a counter SHALL run in REQ/XFER and clear in IDLE. On reaching TIMEOUT_CYC it SHALL drop sd_rd/sd_wr, set io_err=1 and io_done=1, and return to IDLE.
REQ-025 Without SD_BRIDGE_TIMEOUT_EN, no counter SHALL exist, TIMEOUT_CYC SHALL be ignored, and REQ/XFER SHALL wait indefinitely.

Verification
REQ-026 Stimulus: cmd_lba_wr with data 0x00001234, then cmd_rd with drv 2, ack high 5 cycles, 512 sd_buff_wr of i&0xFF. Response: sd_lba=0x1234, sd_rd=4'b0100 for exactly the cycles up to ack, io_done=1 one cycle after ack fall, and buf_q reads 0x00..0xFF twice.
REQ-027 Stimulus: mount drive 1 with img_readonly=1 and size 92176, then cmd_wr with drv 1. Response: mnt_toggle flips, mnt_drv=1, mnt_ro=1, mnt_size=92176; io_err=1, io_done=1, sd_wr stays 0.
REQ-028 Stimulus: img_mounted=4'b0110 in a single edge. Response: mnt_drv=1 and a single toggle.
REQ-029 Stimulus: 511 buf_rd pulses, then buf_wr and buf_rd together, then buf_rd and buf_rst together. Response: ptr goes 511 -> 0 (wrap), then to 0 after buf_rst.
REQ-030 Stimulus: with the macro defined and TIMEOUT_CYC=100, cmd_rd with ack never asserted. Response: sd_rd drops at cycle 101, io_err=1, io_done=1; a second cmd_rd is then accepted.
REQ-031 Stimulus: areset asserted while in XFER. Response: all outputs match REQ-022 on the next cycle.
